// File: rtl/rr_arbiter8_if.sv
// Bus bundle between the requesters and the eight-way round-robin arbiter.
// The master side drives enable and requests; the slave side (the arbiter)
// returns the one-hot grant, its binary index and the busy flag.
interface rr_arbiter8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  busy
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output busy
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant.
// The owner keeps the grant while it requests; priority rotates from the
// most recent owner, and an optional hold timeout forces rotation when
// another requester is waiting.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         rst,
    rr_arbiter8_if.slave bus
);

    // Hold counter must represent 0..MAX_HOLD, never narrower than one bit.
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_EXP = HW'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    gnt_id_q, gnt_id_d;
    logic          busy_q, busy_d;
    logic [2:0]    last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;

    logic          expired_s;
    logic [3:0]    pick_s;
    logic [7:0]    others_s;
    logic          load_s;
    logic [2:0]    win_s;

    // First set bit of r searching base+1, base+2, ... base+8 (mod 8).
    // Result is {found, index}. Iterating backwards lets the earliest
    // position in search order overwrite later ones.
    function automatic logic [3:0] find_next(input logic [7:0] r,
                                             input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int off = 8; off >= 1; off--) begin
            idx = base + off[2:0];
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    // Timeout fires on the edge where the owner completes its MAX_HOLD-th cycle.
    always_comb begin
        expired_s = (MAX_HOLD != 0) && (hold_q == HOLD_EXP);
    end

    // Next-state selection: release, handover, preemption and hold counting.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        hold_d   = hold_q;
        pick_s   = 4'b0000;
        others_s = 8'h00;
        load_s   = 1'b0;
        win_s    = 3'd0;

        if (!bus.en) begin
            // Disabled: drop the grant but remember who went last.
            state_d = IDLE;
            gnt_d   = 8'h00;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pick_s = find_next(bus.req, last_q);
                    if (pick_s[3]) begin
                        load_s = 1'b1;
                        win_s  = pick_s[2:0];
                    end else begin
                        gnt_d = 8'h00;
                    end
                end
                GRANT: begin
                    if (!bus.req[gnt_id_q]) begin
                        // Owner released: hand over without a bubble, or go idle.
                        pick_s = find_next(bus.req, gnt_id_q);
                        if (pick_s[3]) begin
                            load_s = 1'b1;
                            win_s  = pick_s[2:0];
                        end else begin
                            state_d = IDLE;
                            gnt_d   = 8'h00;
                            hold_d  = '0;
                        end
                    end else if (expired_s) begin
                        // Owner used its full slot: preempt only if someone waits.
                        others_s = bus.req & ~onehot(gnt_id_q);
                        if (others_s != 8'h00) begin
                            pick_s = find_next(others_s, gnt_id_q);
                            load_s = 1'b1;
                            win_s  = pick_s[2:0];
                        end else begin
                            hold_d = '0;
                        end
                    end else if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + HW'(1);
                    end else begin
                        hold_d = hold_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = 8'h00;
                    hold_d  = '0;
                end
            endcase
        end

        if (load_s) begin
            state_d  = GRANT;
            gnt_d    = onehot(win_s);
            gnt_id_d = win_s;
            last_d   = win_s;
            hold_d   = '0;
        end else begin
            win_s = win_s;
        end

        busy_d = (gnt_d != 8'h00);
    end

    // State and output registers; last resets to 7 so requester 0 leads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 8'h00;
            gnt_id_q <= 3'd0;
            busy_q   <= 1'b0;
            last_q   <= 3'd7;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.gnt    = gnt_q;
        bus.gnt_id = gnt_id_q;
        bus.busy   = busy_q;
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized
// traffic, compared each cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

    localparam int MAXH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rr_arbiter8_if bus_if();

    rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state
    int m_owner;   // -1 when idle
    int m_last;
    int m_hold;
    int m_id;      // last granted index, retained in idle

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // First requester set in r, scanning base+1 .. base+8 modulo 8.
    function automatic int search(input int base, input logic [7:0] r);
        for (int off = 1; off <= 8; off++) begin
            int j;
            j = (base + off) % 8;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_hold  = 0;
        m_id    = 0;
    endtask

    task automatic take(input int w);
        m_owner = w;
        m_last  = w;
        m_id    = w;
        m_hold  = 0;
    endtask

    task automatic model_edge(input logic en, input logic [7:0] r);
        int w;
        logic [7:0] others;
        if (!en) begin
            m_owner = -1;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            w = search(m_last, r);
            if (w >= 0) take(w);
        end else if (!r[m_owner]) begin
            w = search(m_owner, r);
            if (w >= 0) take(w);
            else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end else if (MAXH != 0 && m_hold == MAXH - 1) begin
            others = r;
            others[m_owner] = 1'b0;
            if (others != 8'h00) take(search(m_owner, others));
            else m_hold = 0;
        end else begin
            m_hold = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
        end
    endtask

    function automatic logic [7:0] exp_gnt();
        logic [7:0] g;
        g = 8'h00;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic compare(input string tag);
        chk({tag, ".gnt"}, {24'h0, bus_if.gnt}, {24'h0, exp_gnt()});
        chk({tag, ".busy"}, {31'h0, bus_if.busy}, {31'h0, (m_owner >= 0)});
        chk({tag, ".gnt_id"}, {29'h0, bus_if.gnt_id}, m_id);
    endtask

    // Drive inputs, take one edge, update model, sample 1ns after the edge.
    task automatic step(input logic en, input logic [7:0] r, input string tag);
        bus_if.en  = en;
        bus_if.req = r;
        @(posedge clk);
        model_edge(en, r);
        #1;
        compare(tag);
    endtask

    int run_len;
    int runs[$];
    logic [7:0] prev_g;
    logic [7:0] rq;
    logic       re;

    initial begin
        checks   = 0;
        failures = 0;
        rst        = 1'b1;
        bus_if.en  = 1'b0;
        bus_if.req = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare("reset");
        @(negedge clk);
        rst = 1'b0;

        // Requester 0 wins first after reset
        step(1'b1, 8'hFF, "first");
        chk("first_gnt01", {24'h0, bus_if.gnt}, 32'h01);

        // Rotation: each owner keeps 2 cycles, then drops for one cycle
        prev_g = bus_if.gnt;
        for (int i = 0; i < 16; i++) begin
            rq = 8'hFF;
            if (i % 2 == 0) rq[m_owner] = 1'b0;
            else rq = 8'hFF;
            step(1'b1, rq, "rotate");
            if (i % 2 == 0)
                chk("rotate_order", {24'h0, bus_if.gnt},
                    {24'h0, (prev_g << 1) | (prev_g >> 7)});
            else prev_g = prev_g;
            prev_g = bus_if.gnt;
        end

        // Wrap with sparse requests: last=6 then 0 and 2 request
        step(1'b0, 8'h00, "idle0");
        step(1'b1, 8'h40, "own6");
        step(1'b1, 8'h05, "wrap");
        chk("wrap_to0", {24'h0, bus_if.gnt}, 32'h01);

        // Timeout alternation with two constant requesters
        step(1'b0, 8'h00, "idle1");
        run_len = 0;
        prev_g  = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h03, "timeout");
            if (bus_if.gnt == prev_g) run_len++;
            else begin
                if (prev_g != 8'h00) runs.push_back(run_len);
                run_len = 1;
            end
            prev_g = bus_if.gnt;
        end
        chk("timeout_runs", runs.size(), 4);
        for (int i = 1; i < runs.size(); i++) chk("timeout_len", runs[i], MAXH);

        // Single requester keeps grant indefinitely
        step(1'b0, 8'h00, "idle2");
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'h01, "solo");
            chk("solo_held", {24'h0, bus_if.gnt}, 32'h01);
        end

        // Enable drop during grant to 3, then resume with all requesting
        step(1'b0, 8'h00, "idle3");
        step(1'b1, 8'h08, "own3");
        step(1'b0, 8'h08, "en_off");
        chk("en_off_busy", {31'h0, bus_if.busy}, 32'h0);
        step(1'b1, 8'hFF, "en_on");
        chk("en_on_gnt4", {24'h0, bus_if.gnt}, 32'h10);

        // Asynchronous reset between edges while gnt=8'h20
        step(1'b0, 8'h00, "idle4");
        step(1'b1, 8'h20, "own5");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_gnt", {24'h0, bus_if.gnt}, 32'h00);
        chk("async_rst_busy", {31'h0, bus_if.busy}, 32'h0);
        rst = 1'b0;
        step(1'b1, 8'h20, "post_rst");
        chk("post_rst_gnt", {24'h0, bus_if.gnt}, 32'h20);

        // Randomized traffic
        rq = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
            else if ($urandom_range(0, 3) == 0 && m_owner >= 0) rq[m_owner] = 1'b0;
            else rq = rq;
            re = ($urandom_range(0, 19) != 0);
            step(re, rq, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource among eight requesters and drives the resource's one-hot select. Requests arrive as an 8-bit vector; the block issues a registered one-hot grant plus its 3-bit binary index, holds the grant while the owner keeps requesting, and rotates priority so that no requester starves. An optional hold timeout forces rotation when a single owner monopolises the resource.

## Interface
- MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant while another request is pending; 0 disables the timeout
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  arbiter enable; 0 releases any grant and blocks new grants
- req  input  8  request vector, bit i = requester i; held high for the whole transaction
- gnt  output  8  registered one-hot grant, all-zero when idle
- gnt_id  output  3  binary index of the granted requester; valid only when busy=1
- busy  output  1  high whenever gnt is non-zero

## Operation
- States: IDLE (gnt=0), GRANT (exactly one gnt bit set).
- Rotation pointer `last` (3 bits) holds the index of the most recent owner. Search order is last+1, last+2, … last+8, modulo 8 (wrap 7→0); the first set req bit in this order wins.
- IDLE → GRANT: en=1 and req≠0. The winner is loaded into gnt/gnt_id, `last` is updated to the winner, and hold_cnt is cleared.
- GRANT, owner k:
  - req[k]=1, not expired: keep the grant and increment hold_cnt (saturates at MAX_HOLD).
  - req[k]=0: pick the next winner from the current req using the search order from k+1. No winner → IDLE. Back-to-back handover has no idle bubble.
  - Expired (MAX_HOLD≠0, hold_cnt=MAX_HOLD-1 at the edge, and some req[j]=1 with j≠k): preempt. The next winner is chosen excluding k, and hold_cnt is cleared.
  - Expired with no other request pending: keep k and restart hold_cnt at 0.
- en=0 at any edge: go to IDLE, gnt=0, busy=0, hold_cnt=0. `last` is retained so fairness resumes correctly.
- gnt_id keeps its last value in IDLE; consumers qualify it with busy.
- Invariants: gnt is always zero or one-hot; busy = |gnt; gnt_id equals the encoded gnt when busy=1.
- hold_cnt width is clog2(MAX_HOLD+1), with a minimum of 1 bit.

## Timing
- Reset (asynchronous, immediate): gnt=8'h00, gnt_id=3'd0, busy=0, state=IDLE, hold_cnt=0, last=3'd7 (requester 0 has first priority after reset).
- All outputs are registered. There is no combinational path from req or en to any output.
- Grant latency: req sampled high at edge N → gnt valid after edge N (one clock from request to grant).
- Release: owner drops req before edge N → after edge N, gnt moves to the next winner or to 0.
- Preemption: the owner holds the grant for exactly MAX_HOLD cycles, then gnt switches on the following edge.
- Simultaneous req drop and timeout expiry: treated as a release; the result is the same winner selection.
- Reset asserted mid-grant: gnt clears immediately with no clock required. After reset deasserts, the first grant follows the rule for last=7.

## Test plan
- Reset/priority: assert rst, check all outputs are 0. Release rst, set req=8'hFF → next edge gnt=8'h01, gnt_id=0, busy=1.
- Rotation: req=8'hFF held and each owner drops its req for one cycle after 2 cycles of ownership → grants go 0,1,2,…,7,0 in order with no idle cycle between owners.
- Wrap and sparse requests: last=6, req=8'b0000_0101 → grant goes to requester 0, not requester 2.
- Timeout: MAX_HOLD=4, req=8'h03 held constantly → gnt=8'h01 for exactly 4 cycles, then 8'h02 for 4 cycles, alternating. With req=8'h01 only → grant held indefinitely.
- Enable: en drops during a grant to requester 3 → next edge gnt=0, busy=0. en returns with req=8'hFF → grant goes to requester 4.
- Asynchronous reset mid-operation: pulse rst between clock edges while gnt=8'h20 → gnt=0 before the next edge. Then req=8'h20 → gnt=8'h20 one edge later.
